// File: rtl/pio_pkg.sv
// Shared definitions for the capture-input PIO: register map, edge modes, CTRL layout.
package pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] PIO_ADDR_CTRL    = 2'd3;

  typedef enum logic [1:0] {
    PIO_EDGE_RISE = 2'd0,
    PIO_EDGE_FALL = 2'd1,
    PIO_EDGE_ANY  = 2'd2,
    PIO_EDGE_OFF  = 2'd3
  } pio_edge_e;

  localparam int PIO_CTRL_MODE_LSB  = 0;
  localparam int PIO_CTRL_MODE_MSB  = 1;
  localparam int PIO_CTRL_READY_BIT = 2;

endpackage

// File: rtl/pio_capture_in_sync.sv
// Multi-stage synchroniser for the external input bus; output is the last stage.
module pio_sync_bus #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // Shift the raw input through the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[STAGES-2:0], din};
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/pio_capture_in.sv
// Avalon-MM input PIO with synchronised live data, W1C edge capture and maskable level IRQ.
module pio_capture_in
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_EN      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  // Warm-up covers the synchroniser depth plus the prev register so the
  // zeroed reset state never looks like an edge.
  localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(SYNC_STAGES + 1);
  localparam pio_edge_e         MODE_RST  = pio_edge_e'(2'(EDGE_TYPE));

  logic [DATA_WIDTH-1:0] sd;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] irqmask;
  logic [DATA_WIDTH-1:0] edgecap;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;
  logic [DATA_WIDTH-1:0] ev;
  logic [DATA_WIDTH-1:0] clr;
  logic [WARM_W-1:0]     warm_cnt;
  logic [31:0]           rd_next;
  pio_edge_e             mode;
  logic                  ready;
  logic                  wr_en;
  logic                  rd_en;

  pio_sync_bus #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (in_port),
    .dout    (sd)
  );

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & write_n;
  assign ready = (warm_cnt == '0);
  assign rise  = sd & ~prev;
  assign fall  = ~sd & prev;

  // Select the edge events enabled by the current mode, held off during warm-up.
  always_comb begin
    ev = '0;
    if (ready) begin
      case (mode)
        PIO_EDGE_RISE: ev = rise;
        PIO_EDGE_FALL: ev = fall;
        PIO_EDGE_ANY:  ev = rise | fall;
        default:       ev = '0;
      endcase
    end
  end

  // W1C clear mask, only on a write to EDGECAP.
  always_comb begin
    clr = '0;
    if (wr_en && address == PIO_ADDR_EDGECAP) clr = writedata[DATA_WIDTH-1:0];
  end

  // Previous-sample register and warm-up down-counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev     <= '0;
      warm_cnt <= WARM_LOAD;
    end else begin
      prev <= sd;
      if (!ready) warm_cnt <= warm_cnt - WARM_W'(1);
    end
  end

  // Software-visible registers; a fresh event beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
      mode    <= MODE_RST;
    end else begin
      edgecap <= (edgecap & ~clr) | ev;
      if (wr_en && address == PIO_ADDR_IRQMASK && IRQ_EN != 0)
        irqmask <= writedata[DATA_WIDTH-1:0];
      if (wr_en && address == PIO_ADDR_CTRL)
        mode <= pio_edge_e'(writedata[PIO_CTRL_MODE_MSB:PIO_CTRL_MODE_LSB]);
    end
  end

  // Read mux; unused upper bits stay zero.
  always_comb begin
    rd_next = '0;
    case (address)
      PIO_ADDR_DATA:    rd_next[DATA_WIDTH-1:0] = sd;
      PIO_ADDR_IRQMASK: rd_next[DATA_WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGECAP: rd_next[DATA_WIDTH-1:0] = edgecap;
      default: begin
        rd_next[PIO_CTRL_MODE_MSB:PIO_CTRL_MODE_LSB] = mode;
        rd_next[PIO_CTRL_READY_BIT]                  = ready;
      end
    endcase
  end

  // Registered read data, zero whenever no read is presented.
  always_ff @(posedge clk) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= rd_next;
    else            readdata <= '0;
  end

  assign irq = (IRQ_EN != 0) && |(edgecap & irqmask);

endmodule

// File: tb/tb_pio_capture_in.sv
// Self-checking bench: 32-bit and 8-bit instances on one bus, checked each cycle
// against an input-history model, plus directed literal expectations.
module tb_pio_capture_in;

  localparam int EDGE_TYPE = 0;
  localparam int HIST      = 4096;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata8;
  logic [31:0] in_port;
  logic        irq;
  logic        irq8;

  int n_checks = 0;
  int n_fail   = 0;

  pio_capture_in #(.DATA_WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_TYPE), .IRQ_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  pio_capture_in #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_TYPE), .IRQ_EN(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata8),
    .in_port(in_port[7:0]), .irq(irq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Every edge k records in_port as presented before it. With a two-stage
  // synchroniser the live value before edge k is the sample taken at edge k-2,
  // provided that sample came after the last reset edge (otherwise zero).
  logic [31:0] samp [HIST];
  int          k        = 0;
  int          rst_edge = -1;
  bit          valid    = 0;
  logic [31:0] m_ecap, m_mask, m_rd;
  logic [1:0]  m_mode;

  function automatic logic [31:0] live_before(int e);
    if (e - 2 > rst_edge) return samp[(e - 2) % HIST];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    logic [31:0] cur, prv, ev, clr;
    logic        rdy;
    samp[k % HIST] = in_port;
    if (!reset_n) begin
      rst_edge = k;
      valid    = 1;
      m_ecap   = 0;
      m_mask   = 0;
      m_rd     = 0;
      m_mode   = 2'(EDGE_TYPE);
    end else if (valid) begin
      cur = live_before(k);
      prv = live_before(k - 1);
      ev  = 0;
      // An edge is only genuine when both compared samples postdate reset.
      if (k - 3 > rst_edge) begin
        case (m_mode)
          2'd0: ev = cur & ~prv;
          2'd1: ev = ~cur & prv;
          2'd2: ev = cur ^ prv;
          default: ev = 0;
        endcase
      end
      rdy = ((k - 1) - rst_edge) >= 3;
      m_rd = 0;
      if (chipselect && write_n) begin
        case (address)
          2'd0: m_rd = cur;
          2'd1: m_rd = m_mask;
          2'd2: m_rd = m_ecap;
          default: m_rd = {29'd0, rdy, m_mode};
        endcase
      end
      clr = 0;
      if (chipselect && !write_n) begin
        case (address)
          2'd1: m_mask = writedata;
          2'd2: clr = writedata;
          2'd3: m_mode = writedata[1:0];
          default: ;
        endcase
      end
      m_ecap = (m_ecap & ~clr) | ev;
    end
    k++;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (valid) begin
      check("readdata32", readdata, m_rd);
      check("irq32", {31'd0, irq}, {31'd0, |(m_ecap & m_mask)});
      check("readdata8", readdata8, m_rd & 32'hFF);
      check("irq8", {31'd0, irq8}, {31'd0, |(m_ecap[7:0] & m_mask[7:0])});
    end
  end

  // ---------------- bus tasks (entered and left on a negedge) ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 0; write_n = 1; writedata = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d, output logic [31:0] d8);
    chipselect = 1; write_n = 1; address = a;
    @(negedge clk);
    chipselect = 0;
    d  = readdata;
    d8 = readdata8;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] r, r8;
    reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0;
    in_port = 32'hFFFF_FFFF;
    wait_clk(3);
    reset_n = 1;

    // 1: warm-up with all inputs high
    rd(2'd3, r, r8); check("t1 ctrl c1", r, 32'h0);
    rd(2'd3, r, r8); check("t1 ctrl c2", r, 32'h0);
    rd(2'd3, r, r8); check("t1 ctrl c3", r, 32'h0);
    rd(2'd3, r, r8); check("t1 ctrl ready", r, 32'h4);
    rd(2'd0, r, r8); check("t1 data", r, 32'hFFFF_FFFF); check("t1 data8", r8, 32'h0000_00FF);
    rd(2'd2, r, r8); check("t1 edgecap", r, 32'h0);
    check("t1 irq", {31'd0, irq}, 32'h0);

    // 2: rising edge on bit0, unmasked, then W1C
    in_port = 32'h0; wait_clk(4);
    wr(2'd1, 32'h1);
    in_port = 32'h1;
    wait_clk(3);
    check("t2 irq set", {31'd0, irq}, 32'h1);
    rd(2'd2, r, r8); check("t2 edgecap", r, 32'h1);
    wr(2'd2, 32'h1);
    check("t2 irq clr", {31'd0, irq}, 32'h0);
    rd(2'd2, r, r8); check("t2 edgecap clr", r, 32'h0);

    // 3: falling, any, off modes on bit5
    wr(2'd3, 32'h1);
    in_port = 32'h21; wait_clk(4);
    in_port = 32'h01; wait_clk(4);
    rd(2'd2, r, r8); check("t3 fall only", r, 32'h20);
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'h2);
    in_port = 32'h21; wait_clk(4);
    rd(2'd2, r, r8); check("t3 any rise", r, 32'h20);
    wr(2'd2, 32'hFFFF_FFFF);
    in_port = 32'h01; wait_clk(4);
    rd(2'd2, r, r8); check("t3 any fall", r, 32'h20);
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'h3);
    in_port = 32'h21; wait_clk(4);
    in_port = 32'h01; wait_clk(4);
    rd(2'd2, r, r8); check("t3 off", r, 32'h0);
    rd(2'd3, r, r8); check("t3 ctrl", r, 32'h7);

    // 4: event on bit3 coincides with its W1C
    wr(2'd3, 32'h0);
    in_port = 32'h09;
    wait_clk(2);
    wr(2'd2, 32'h8);
    rd(2'd2, r, r8); check("t4 event wins", r, 32'h8);

    // 5: pending captures held off by the mask
    in_port = 32'h0; wait_clk(4);
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd1, 32'h0);
    in_port = 32'hF0; wait_clk(4);
    check("t5 irq masked", {31'd0, irq}, 32'h0);
    rd(2'd2, r, r8); check("t5 edgecap", r, 32'hF0);
    wr(2'd1, 32'h10);
    check("t5 irq unmask", {31'd0, irq}, 32'h1);
    rd(2'd1, r, r8); check("t5 irqmask", r, 32'h10);

    // 6: mid-operation reset
    wr(2'd3, 32'h2);
    in_port = 32'hFF; wait_clk(4);
    wr(2'd1, 32'hFF);
    rd(2'd2, r, r8); check("t6 edgecap pre", r, 32'hFF); check("t6 edgecap8 pre", r8, 32'hFF);
    check("t6 irq pre", {31'd0, irq}, 32'h1);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    check("t6 irq post", {31'd0, irq}, 32'h0);
    check("t6 readdata post", readdata, 32'h0);
    rd(2'd2, r, r8); check("t6 edgecap post", r, 32'h0);
    rd(2'd1, r, r8); check("t6 irqmask post", r, 32'h0);
    rd(2'd3, r, r8); check("t6 ctrl warm", r, 32'h0);
    wait_clk(4);
    rd(2'd3, r, r8); check("t6 ctrl ready", r, 32'h4);
    rd(2'd0, r, r8); check("t6 data", r, 32'hFF); check("t6 data8", r8, 32'hFF);
    in_port = 32'hA5A5_A5A5; wait_clk(4);
    rd(2'd0, r, r8); check("t6 data8 upper", r8, 32'hA5);
    wait_clk(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
